// File: rtl/output_port_allocator_pkg.sv
// Shared definitions for the output port allocator and its neighbours
// (head-flit decoder, input buffers): FSM encodings, flit geometry and
// the default head/tail flag positions.
package output_port_allocator_pkg;

  // Allocator FSM encodings
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Default router geometry
  localparam int DEF_NUM_INPUTS    = 4;
  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_PHIT_PER_FLIT = 2;

  // A flit is a whole number of phits
  function automatic int flit_width(input int data_width, input int phit_per_flit);
    return data_width * phit_per_flit;
  endfunction

  // Head flag sits in the MSB of a flit
  function automatic int head_bit(input int fw);
    return fw - 1;
  endfunction

  // Tail flag sits just below the head flag
  function automatic int tail_bit(input int fw);
    return fw - 2;
  endfunction

  // Width of an index into NUM_INPUTS ports (at least one bit)
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/output_port_allocator_rr_arbiter.sv
// Combinational round-robin priority select. Scans the request vector
// starting at i_ptr, wrapping modulo N; the first set bit wins. Shared by
// every output port of the router.
module rr_arbiter
  import output_port_allocator_pkg::*;
#(
  parameter int N     = DEF_NUM_INPUTS,
  parameter int PTR_W = ptr_width(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_found
);

  // Rotating first-hit search from the pointer position
  always_comb begin
    int w_idx;
    o_grant = '0;
    o_idx   = '0;
    o_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(i_ptr) + k) % N;
      if (!o_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_idx          = PTR_W'(w_idx);
        o_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_port_allocator.sv
// Per-output-port wormhole allocator and flit mux for a NoC router.
// Round-robin arbitration among head-flit candidates, grant locked from
// head to tail, owner's flits forwarded with valid/ready flow control.
// Optional build macro ARB_PERF_CNT_EN adds per-input saturating
// packet counters on port pkt_count.
module output_port_allocator
  import output_port_allocator_pkg::*;
#(
  parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int PhitPerFlit = DEF_PHIT_PER_FLIT,
  parameter int FLIT_WIDTH  = flit_width(DATA_WIDTH, PhitPerFlit),
  parameter int HEAD_BIT    = head_bit(FLIT_WIDTH),
  parameter int TAIL_BIT    = tail_bit(FLIT_WIDTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS-1:0]            req,
  input  logic [NUM_INPUTS*FLIT_WIDTH-1:0] in_flit,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]            out_flit,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_INPUTS-1:0]            grant,
  output logic                             busy
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [NUM_INPUTS*16-1:0]         pkt_count
`endif
);

  localparam int PTR_W = ptr_width(NUM_INPUTS);

  logic [0:0]            r_state;
  logic [NUM_INPUTS-1:0] r_grant;
  logic [PTR_W-1:0]      r_rr_ptr;
  logic [PTR_W-1:0]      r_owner_idx;

  logic [NUM_INPUTS-1:0] w_cand;
  logic [NUM_INPUTS-1:0] w_win;
  logic [PTR_W-1:0]      w_win_idx;
  logic                  w_found;
  logic [FLIT_WIDTH-1:0] w_out_flit;
  logic                  w_owner_valid;
  logic                  w_locked;
  logic                  w_xfer;
  logic                  w_tail_xfer;
  logic [PTR_W-1:0]      w_next_ptr;

  // Candidate = requesting this output with a valid head flit present
  always_comb begin
    w_cand = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      w_cand[i] = req[i] & in_valid[i] & in_flit[i*FLIT_WIDTH + HEAD_BIT];
    end
  end

  rr_arbiter #(
    .N     (NUM_INPUTS),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .i_req   (w_cand),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_win),
    .o_idx   (w_win_idx),
    .o_found (w_found)
  );

  // Owner mux; grant is zero outside LOCKED so everything collapses to 0
  always_comb begin
    w_out_flit    = '0;
    w_owner_valid = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (r_grant[i]) begin
        w_out_flit    = w_out_flit | in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
        w_owner_valid = w_owner_valid | in_valid[i];
      end
    end
  end

  assign w_locked    = (r_state == ST_LOCKED);
  assign w_xfer      = w_locked & w_owner_valid & out_ready;
  assign w_tail_xfer = w_xfer & w_out_flit[TAIL_BIT];
  assign w_next_ptr  = (r_owner_idx == PTR_W'(NUM_INPUTS - 1)) ? '0 : r_owner_idx + 1'b1;

  assign out_flit  = w_out_flit;
  assign out_valid = w_owner_valid;
  assign in_ready  = r_grant & {NUM_INPUTS{out_ready}};
  assign grant     = r_grant;
  assign busy      = w_locked;

  // Arbitrate in IDLE, hold the lock until the owner's tail transfers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_owner_idx <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state     <= ST_LOCKED;
            r_grant     <= w_win;
            r_owner_idx <= w_win_idx;
          end
        end
        default: begin
          if (w_tail_xfer) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= w_next_ptr;
          end
        end
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [15:0] r_pkt_cnt [NUM_INPUTS];

  // Count completed packets per input, saturating at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_INPUTS; i++) r_pkt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (w_tail_xfer && r_grant[i] && (r_pkt_cnt[i] != 16'hFFFF)) begin
          r_pkt_cnt[i] <= r_pkt_cnt[i] + 16'd1;
        end
      end
    end
  end

  // Flatten counters onto the output port
  always_comb begin
    pkt_count = '0;
    for (int i = 0; i < NUM_INPUTS; i++) pkt_count[i*16 +: 16] = r_pkt_cnt[i];
  end
`endif

endmodule

// File: doc/output_port_allocator.md
Name: output_port_allocator

Overview:
- Per-output-port wormhole allocator and flit mux for a NoC router.
- Sits after the per-input head-flit decoders. Each decoder's request message is one-hot-expanded by the router into a req bit per output port.
- Arbitrates round-robin among input ports requesting this output and locks the grant for the whole packet (head to tail).
- Multiplexes the winner's flits onto the output link with valid/ready flow control.

Parameters:
- NUM_INPUTS, 4, number of input ports competing for this output.
- DATA_WIDTH, 8, phit width in bits.
- PhitPerFlit, 2, phits per flit; FLIT_WIDTH = PhitPerFlit*DATA_WIDTH.
- HEAD_BIT, FLIT_WIDTH-1, bit position of the head flag inside a flit.
- TAIL_BIT, FLIT_WIDTH-2, bit position of the tail flag inside a flit.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_INPUTS  req[i]=1: input i's decoded head flit targets this output.
- in_flit  input  NUM_INPUTS*FLIT_WIDTH  flattened input flits; input i is at [i*FLIT_WIDTH +: FLIT_WIDTH].
- in_valid  input  NUM_INPUTS  per-input flit valid.
- in_ready  output  NUM_INPUTS  per-input ready back to the input buffers.
- out_flit  output  FLIT_WIDTH  flit to the downstream link.
- out_valid  output  1  out_flit valid.
- out_ready  input  1  downstream can accept.
- grant  output  NUM_INPUTS  one-hot current owner, or all-zero.
- busy  output  1  1 while LOCKED.

Behaviour:
- Reset values: state=IDLE, grant=0, rr_ptr=0, busy=0, out_valid=0, in_ready=0, out_flit=0 (combinationally, via grant=0).
- Candidate i: req[i] & in_valid[i] & in_flit[i][HEAD_BIT].
- IDLE state:
  - Search candidates starting at index rr_ptr, wrapping modulo NUM_INPUTS; the first hit wins.
  - The winner is registered into grant and the FSM goes to LOCKED on the next edge (request-to-grant latency 1 cycle).
  - No flit transfers in IDLE; in_ready=0 and out_valid=0.
  - With no candidate, stay IDLE.
- LOCKED state, owner g:
  - out_flit = in_flit[g], out_valid = in_valid[g].
  - in_ready[g] = out_ready; in_ready of every other input = 0. All purely combinational.
  - A transfer occurs when in_valid[g] & out_ready.
  - Transfer of a flit with TAIL_BIT=1: next state IDLE, grant=0, rr_ptr=(g+1) mod NUM_INPUTS.
  - A single-flit packet (HEAD and TAIL both set) transfers in one cycle and releases.
- After each tail there is one mandatory IDLE cycle; re-arbitration never happens in the tail cycle.
- While LOCKED, the following are ignored and the lock is held: req changes, in_valid[g] bubbles, out_ready stalls of any length.
- A HEAD-flagged flit from the owner while LOCKED is forwarded as data; it does not re-arbitrate.
- Simultaneous requests: exactly one winner per rr_ptr rule. The round-robin starvation bound is NUM_INPUTS-1 packets.
- Reset mid-packet: lock is dropped immediately and state returns to IDLE; upstream buffers are responsible for discarding partial packets.
- grant is always one-hot or zero (assertion in verification).

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - Adds output port pkt_count, width NUM_INPUTS*16.
  - Per-input 16-bit counter increments on each tail transfer from that input and saturates at 16'hFFFF.
  - rst clears the counters.
- Undefined: port and counters absent; all other behaviour identical.

Decomposition:
- Shared package/header:
  - FSM state encodings IDLE=1'b0, LOCKED=1'b1.
  - FLIT_WIDTH derivation.
  - HEAD_BIT/TAIL_BIT defaults, shared with the head-flit decoder and input buffers.
- One natural sub-module: rr_arbiter. Combinational round-robin priority select from request vector and rr_ptr, returning a one-hot winner and a found flag. It is reused by the router's other output ports.

Test Plan:
- Single request: req=4'b0010, input 1 sends head 16'h8003 then tail 16'h4005, out_ready=1 -> grant=4'b0010 one cycle after request; both flits on out_flit in order; grant=0 and rr_ptr=2 after the tail.
- Round-robin: all four inputs hold single-flit packets (16'hC000|i) continuously -> grants cycle 0,1,2,3,0 with one IDLE cycle between grants.
- Backpressure: owner sends 3-flit packet, out_ready low for 5 cycles mid-packet -> in_ready[g]=0 during the stall, no flit lost or duplicated, lock held.
- Contention while locked: input 2 locked; input 0 raises head+req -> input 0's in_ready stays 0 until input 2's tail passes, then input 0 wins (rr_ptr=3 wraps to 0).
- Owner bubbles: owner in_valid drops 3 cycles between body flits -> out_valid=0 for those cycles, grant unchanged.
- Async reset mid-packet: assert rst between clk edges during LOCKED -> grant=0, out_valid=0, busy=0 immediately; after release the first arbitration starts from rr_ptr=0.
